// File: rtl/score_display_bcd.sv
// score_display_bcd
//   Converts a binary score to BCD with a sequential shift-add-3 converter
//   (one bit per clock), holds the result in a display register that only
//   changes on completion, and produces a registered digit-sprite ROM
//   address for the pixel currently being scanned.
//
// Ports
//   clk, rst          system clock, asynchronous active-high reset
//   score_bin         binary score to convert
//   score_load        request a conversion of score_bin
//   col_addr_sig      current VGA column
//   row_addr_sig      current VGA row
//   busy              conversion in progress
//   conv_done         one-cycle pulse when bcd_out updates
//   overflow          last converted value exceeded 10^DIGITS-1
//   bcd_out           displayed digits, digit 0 in the MSBs
//   pic_num_addr      sprite ROM address for the current pixel
//   pic_num_valid     pixel lies inside a non-blanked digit cell
module score_display_bcd #(
    parameter int BIN_W    = 10,
    parameter int DIGITS   = 4,
    parameter int X0       = 195,
    parameter int Y0       = 283,
    parameter int DIG_W    = 25,
    parameter int DIG_H    = 40,
    parameter int ADDR_W   = 14,
    parameter int LZ_BLANK = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [BIN_W-1:0]      score_bin,
    input  logic                  score_load,
    input  logic [10:0]           col_addr_sig,
    input  logic [10:0]           row_addr_sig,
    output logic                  busy,
    output logic                  conv_done,
    output logic                  overflow,
    output logic [4*DIGITS-1:0]   bcd_out,
    output logic [ADDR_W-1:0]     pic_num_addr,
    output logic                  pic_num_valid
);

    localparam int CNT_W = $clog2(BIN_W + 1);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_CONV = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    function automatic logic [63:0] pow10(input int unsigned n);
        logic [63:0] r;
        r = 64'd1;
        for (int unsigned i = 0; i < n; i++) begin
            r = r * 64'd10;
        end
        return r;
    endfunction

    localparam logic [63:0] MAX_VAL = pow10(DIGITS) - 64'd1;

    localparam logic [ADDR_W-1:0] ROW_STRIDE   = ADDR_W'(10 * DIG_W);
    localparam logic [ADDR_W-1:0] DIGIT_STRIDE = ADDR_W'(DIG_W);

    // ------------------------------------------------------------------
    // Converter state
    // ------------------------------------------------------------------
    logic [1:0]            state_q, state_d;
    logic [BIN_W-1:0]      shift_q, shift_d;
    logic [4*DIGITS-1:0]   work_q, work_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic                  pending_q, pending_d;
    logic                  ovf_next_q, ovf_next_d;
    logic [4*DIGITS-1:0]   bcd_q, bcd_d;
    logic                  ovf_q, ovf_d;
    logic                  done_q, done_d;

    logic [63:0]           score_ext;
    logic [4*DIGITS-1:0]   adj;

    assign score_ext = 64'(score_bin);

    always_comb begin
        state_d    = state_q;
        shift_d    = shift_q;
        work_d     = work_q;
        cnt_d      = cnt_q;
        pending_d  = pending_q;
        ovf_next_d = ovf_next_q;
        bcd_d      = bcd_q;
        ovf_d      = ovf_q;
        done_d     = 1'b0;

        // add-3 correction on every digit that would reach >=10 after doubling
        adj = work_q;
        for (int unsigned i = 0; i < DIGITS; i++) begin
            if (adj[4*i +: 4] >= 4'd5) begin
                adj[4*i +: 4] = adj[4*i +: 4] + 4'd3;
            end
        end

        case (state_q)
            ST_IDLE: begin
                if (score_load) begin
                    shift_d    = score_bin;
                    work_d     = '0;
                    cnt_d      = CNT_W'(BIN_W);
                    ovf_next_d = (score_ext > MAX_VAL);
                    state_d    = ST_CONV;
                end
            end
            ST_CONV: begin
                {work_d, shift_d} = {adj, shift_q} << 1;
                cnt_d = cnt_q - CNT_W'(1);
                if (cnt_q == CNT_W'(1)) begin
                    state_d = ST_DONE;
                end
                if (score_load) begin
                    pending_d = 1'b1;
                end
            end
            ST_DONE: begin
                bcd_d  = ovf_next_q ? {DIGITS{4'h9}} : work_q;
                ovf_d  = ovf_next_q;
                done_d = 1'b1;
                // A load arriving in this very cycle counts as pending, so
                // restart immediately and keep busy asserted without a gap.
                if (pending_q || score_load) begin
                    pending_d  = 1'b0;
                    shift_d    = score_bin;
                    work_d     = '0;
                    cnt_d      = CNT_W'(BIN_W);
                    ovf_next_d = (score_ext > MAX_VAL);
                    state_d    = ST_CONV;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            shift_q    <= '0;
            work_q     <= '0;
            cnt_q      <= '0;
            pending_q  <= 1'b0;
            ovf_next_q <= 1'b0;
            bcd_q      <= '0;
            ovf_q      <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            shift_q    <= shift_d;
            work_q     <= work_d;
            cnt_q      <= cnt_d;
            pending_q  <= pending_d;
            ovf_next_q <= ovf_next_d;
            bcd_q      <= bcd_d;
            ovf_q      <= ovf_d;
            done_q     <= done_d;
        end
    end

    assign busy      = (state_q != ST_IDLE);
    assign conv_done = done_q;
    assign overflow  = ovf_q;
    assign bcd_out   = bcd_q;

    // ------------------------------------------------------------------
    // Pixel path
    // ------------------------------------------------------------------
    logic                 row_in;
    logic [10:0]          row_off;
    logic [DIGITS-1:0]    hit;
    logic [10:0]          col_off [DIGITS];

    assign row_in  = ({1'b0, row_addr_sig} >= 12'(Y0)) &&
                     ({1'b0, row_addr_sig} <  12'(Y0 + DIG_H));
    assign row_off = row_addr_sig - 11'(Y0);

    // Each digit cell has its own constant column window; no divider needed.
    for (genvar k = 0; k < DIGITS; k++) begin : g_cell
        localparam int LO = X0 + k * DIG_W;
        assign hit[k] = row_in &&
                        ({1'b0, col_addr_sig} >= 12'(LO)) &&
                        ({1'b0, col_addr_sig} <  12'(LO + DIG_W));
        assign col_off[k] = col_addr_sig - 11'(LO);
    end

    logic [ADDR_W-1:0] addr_q, addr_d;
    logic              valid_q, valid_d;
    logic              in_box;
    logic              lead_zero;
    logic              sel_blank;
    logic [3:0]        sel_dig;
    logic [3:0]        dig;
    logic [10:0]       sel_off;
    logic [ADDR_W-1:0] addr;

    always_comb begin
        in_box    = 1'b0;
        lead_zero = (LZ_BLANK != 0);
        sel_blank = 1'b0;
        sel_dig   = '0;
        sel_off   = '0;
        dig       = '0;
        for (int unsigned k = 0; k < DIGITS; k++) begin
            dig       = bcd_q[4*(DIGITS-1-k) +: 4];
            // running AND: still zero through every more-significant digit
            lead_zero = lead_zero && (dig == 4'd0);
            if (hit[k]) begin
                in_box    = 1'b1;
                sel_dig   = dig;
                sel_off   = col_off[k];
                sel_blank = lead_zero && (k != DIGITS - 1);
            end
        end

        addr = ADDR_W'(row_off) * ROW_STRIDE
             + ADDR_W'(sel_dig) * DIGIT_STRIDE
             + ADDR_W'(sel_off);

        addr_d  = in_box ? addr : addr_q;
        valid_d = in_box && !sel_blank;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            addr_q  <= '0;
            valid_q <= 1'b0;
        end else begin
            addr_q  <= addr_d;
            valid_q <= valid_d;
        end
    end

    assign pic_num_addr  = addr_q;
    assign pic_num_valid = valid_q;

endmodule

// File: tb/tb_score_display_bcd.sv
// tb_score_display_bcd
//   Directed bench for score_display_bcd: default configuration, a
//   3-digit instance for overflow saturation, and a LZ_BLANK=0 instance
//   for the unblanked display.
module tb_score_display_bcd;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [9:0]  score = '0;
    logic        load = 1'b0;
    logic [9:0]  score3 = '0;
    logic        load3 = 1'b0;
    logic [10:0] col = '0;
    logic [10:0] row = '0;

    logic        busy, conv_done, overflow, valid;
    logic [15:0] bcd;
    logic [13:0] addr;

    logic        busy3, conv_done3, overflow3, valid3;
    logic [11:0] bcd3;
    logic [13:0] addr3;

    logic        busy_n, conv_done_n, overflow_n, valid_n;
    logic [15:0] bcd_n;
    logic [13:0] addr_n;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    score_display_bcd u_dut (
        .clk(clk), .rst(rst), .score_bin(score), .score_load(load),
        .col_addr_sig(col), .row_addr_sig(row),
        .busy(busy), .conv_done(conv_done), .overflow(overflow),
        .bcd_out(bcd), .pic_num_addr(addr), .pic_num_valid(valid)
    );

    score_display_bcd #(.BIN_W(10), .DIGITS(3)) u_dut3 (
        .clk(clk), .rst(rst), .score_bin(score3), .score_load(load3),
        .col_addr_sig(col), .row_addr_sig(row),
        .busy(busy3), .conv_done(conv_done3), .overflow(overflow3),
        .bcd_out(bcd3), .pic_num_addr(addr3), .pic_num_valid(valid3)
    );

    score_display_bcd #(.LZ_BLANK(0)) u_dutn (
        .clk(clk), .rst(rst), .score_bin(score), .score_load(load),
        .col_addr_sig(col), .row_addr_sig(row),
        .busy(busy_n), .conv_done(conv_done_n), .overflow(overflow_n),
        .bcd_out(bcd_n), .pic_num_addr(addr_n), .pic_num_valid(valid_n)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Load v into the default instances; lat = edges from load to conv_done, -1 if none.
    task automatic run_load(input logic [9:0] v, output int lat);
        score = v;
        load  = 1'b1;
        step();
        load  = 1'b0;
        lat   = -1;
        for (int n = 1; n <= 40; n++) begin
            step();
            if (conv_done) begin
                lat = n;
                break;
            end
        end
    endtask

    task automatic run_load3(input logic [9:0] v, output int lat);
        score3 = v;
        load3  = 1'b1;
        step();
        load3  = 1'b0;
        lat    = -1;
        for (int n = 1; n <= 40; n++) begin
            step();
            if (conv_done3) begin
                lat = n;
                break;
            end
        end
    endtask

    initial begin
        int lat;
        int ndone;
        int d1_cyc, d2_cyc;
        logic [15:0] d1_bcd, d2_bcd;
        int busy_gaps;
        int spurious;

        // ---- reset state ----
        step();
        step();
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(conv_done), 32'd0);
        check("rst_bcd", 32'(bcd), 32'h0);
        check("rst_addr", 32'(addr), 32'd0);
        check("rst_valid", 32'(valid), 32'd0);
        rst = 1'b0;
        step();

        // ---- single conversion: 255 ----
        run_load(10'd255, lat);
        check("lat_255", 32'(lat), 32'd11);
        check("bcd_255", 32'(bcd), 32'h0255);
        check("ovf_255", 32'(overflow), 32'd0);
        step();
        check("busy_idle", 32'(busy), 32'd0);
        check("done_pulse", 32'(conv_done), 32'd0);

        // ---- pixel path on 0255 ----
        row = 11'd290; col = 11'd246;
        step();
        check("pix_addr_246", 32'(addr), 32'd1876);
        check("pix_valid_246", 32'(valid), 32'd1);
        col = 11'd200;
        step();
        check("pix_valid_200", 32'(valid), 32'd0);
        check("pix_addr_200", 32'(addr), 32'd1755);
        col = 11'd300;
        step();
        check("pix_valid_300", 32'(valid), 32'd0);
        check("pix_hold_300", 32'(addr), 32'd1755);

        // ---- pending loads collapse ----
        score = 10'd255;
        load  = 1'b1;
        step();                     // E0
        ndone = 0; d1_cyc = -1; d2_cyc = -1; d1_bcd = '0; d2_bcd = '0; busy_gaps = 0;
        for (int c = 1; c <= 40; c++) begin
            if (c == 3) begin
                load = 1'b1; score = 10'd999;
            end else if (c == 5) begin
                load = 1'b1; score = 10'd1000;
            end else begin
                load = 1'b0;
            end
            step();                 // edge Ec
            if (c < 22 && !busy) busy_gaps++;
            if (conv_done) begin
                ndone++;
                if (ndone == 1) begin
                    d1_cyc = c; d1_bcd = bcd;
                end else if (ndone == 2) begin
                    d2_cyc = c; d2_bcd = bcd;
                end
            end
        end
        check("pend_ndone", 32'(ndone), 32'd2);
        check("pend_d1_cyc", 32'(d1_cyc), 32'd11);
        check("pend_d1_bcd", 32'(d1_bcd), 32'h0255);
        check("pend_d2_cyc", 32'(d2_cyc), 32'd22);
        check("pend_d2_bcd", 32'(d2_bcd), 32'h1000);
        check("pend_busy_gap", 32'(busy_gaps), 32'd0);
        check("pend_ovf", 32'(overflow), 32'd0);
        check("pend_idle", 32'(busy), 32'd0);

        // ---- reset mid-conversion ----
        run_load(10'd255, lat);
        row = 11'd290; col = 11'd246;
        step();
        check("pre_rst_valid", 32'(valid), 32'd1);
        score = 10'd77;
        load  = 1'b1;
        step();
        load  = 1'b0;
        step();
        step();
        check("pre_rst_busy", 32'(busy), 32'd1);
        rst = 1'b1;
        #1;
        check("mid_rst_busy", 32'(busy), 32'd0);
        check("mid_rst_bcd", 32'(bcd), 32'h0);
        check("mid_rst_addr", 32'(addr), 32'd0);
        check("mid_rst_valid", 32'(valid), 32'd0);
        step();
        rst = 1'b0;
        spurious = 0;
        for (int n = 0; n < 20; n++) begin
            step();
            if (conv_done) spurious++;
        end
        check("post_rst_done", 32'(spurious), 32'd0);
        check("post_rst_busy", 32'(busy), 32'd0);

        // ---- 3-digit saturation ----
        run_load3(10'd1000, lat);
        check("d3_lat", 32'(lat), 32'd11);
        check("d3_bcd_1000", 32'(bcd3), 32'h999);
        check("d3_ovf_1000", 32'(overflow3), 32'd1);
        run_load3(10'd7, lat);
        check("d3_bcd_7", 32'(bcd3), 32'h007);
        check("d3_ovf_7", 32'(overflow3), 32'd0);

        // ---- score 0: leading-zero blanking vs. unblanked ----
        run_load(10'd0, lat);
        check("zero_bcd", 32'(bcd), 32'h0);
        check("zero_bcd_n", 32'(bcd_n), 32'h0);
        row = 11'd290;
        col = 11'd200; step();
        check("z_v_200", 32'(valid), 32'd0);
        check("z_vn_200", 32'(valid_n), 32'd1);
        check("z_an_200", 32'(addr_n), 32'd1755);
        col = 11'd230; step();
        check("z_v_230", 32'(valid), 32'd0);
        check("z_vn_230", 32'(valid_n), 32'd1);
        col = 11'd250; step();
        check("z_v_250", 32'(valid), 32'd0);
        check("z_vn_250", 32'(valid_n), 32'd1);
        col = 11'd280; step();
        check("z_v_280", 32'(valid), 32'd1);
        check("z_a_280", 32'(addr), 32'd1760);
        check("z_vn_280", 32'(valid_n), 32'd1);

        // ---- box edges ----
        col = 11'd195; step();
        check("e_vn_195", 32'(valid_n), 32'd1);
        check("e_an_195", 32'(addr_n), 32'd1750);
        col = 11'd194; step();
        check("e_vn_194", 32'(valid_n), 32'd0);
        check("e_an_194", 32'(addr_n), 32'd1750);
        col = 11'd294; step();
        check("e_v_294", 32'(valid), 32'd1);
        check("e_a_294", 32'(addr), 32'd1774);
        col = 11'd295; step();
        check("e_v_295", 32'(valid), 32'd0);
        check("e_a_295", 32'(addr), 32'd1774);
        row = 11'd283; col = 11'd270; step();
        check("e_v_top", 32'(valid), 32'd1);
        check("e_a_top", 32'(addr), 32'd0);
        row = 11'd282; step();
        check("e_v_above", 32'(valid), 32'd0);
        row = 11'd322; step();
        check("e_v_bot", 32'(valid), 32'd1);
        check("e_a_bot", 32'(addr), 32'd9750);
        row = 11'd323; step();
        check("e_v_below", 32'(valid), 32'd0);
        check("e_a_below", 32'(addr), 32'd9750);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/score_display_bcd.md
# score_display_bcd

Parametrised score display engine for the Tetris VGA pipeline. It converts a BIN_W-bit binary score to DIGITS BCD digits with a sequential shift-add-3 converter, one bit per clock. It holds the converted digits in a display register that only updates on completion, so the shown score never tears mid-conversion. It generates the registered digit-sprite ROM address, with a valid flag and optional leading-zero blanking, for the pixel currently being scanned.

## Interface
Parameters:
- BIN_W, 10, binary score width (≥1)
- DIGITS, 4, BCD digits displayed; 4·DIGITS bits of bcd_out
- X0, 195, leftmost column of digit 0 (most significant)
- Y0, 283, top row of digit box
- DIG_W, 25, digit glyph width in pixels
- DIG_H, 40, digit glyph height in pixels
- ADDR_W, 14, sprite ROM address width; must hold DIG_H·10·DIG_W−1
- LZ_BLANK, 1, 1 = blank leading zero digits

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous, active-high reset
- score_bin  in  BIN_W  binary score
- score_load  in  1  request conversion of score_bin
- col_addr_sig  in  11  current VGA column
- row_addr_sig  in  11  current VGA row
- busy  out  1  conversion in progress
- conv_done  out  1  one-cycle pulse when bcd_out updates
- overflow  out  1  last converted value exceeded 10^DIGITS−1
- bcd_out  out  4·DIGITS  displayed digits, digit 0 in MSBs
- pic_num_addr  out  ADDR_W  sprite ROM address
- pic_num_valid  out  1  pixel is inside a non-blanked digit cell

## Operation
- States: IDLE, CONV, DONE.
- IDLE with score_load=1:
  - latch score_bin into shift register; clear work digits; bit counter = BIN_W;
  - overflow_next = (score_bin > 10^DIGITS−1), a localparam constant;
  - go to CONV.
- CONV, each cycle:
  - every work digit ≥5 gets +3 (4-bit, no carry);
  - then shift {work digits, shift register} left by 1;
  - decrement counter; when counter reaches 0 after this shift, go to DONE.
- DONE (one cycle):
  - bcd_out ← work digits, or all 9s if overflow_next;
  - overflow ← overflow_next; conv_done=1;
  - if pending set: clear pending, reload from current score_bin, go to CONV; else go to IDLE.
- score_load while busy (CONV or DONE): set pending. Repeated loads collapse to one, and the value used is score_bin at restart. A load in the same cycle as DONE is also captured as pending.
- busy = (state ≠ IDLE).
- Pixel path: the box is col ∈ [X0, X0+DIGITS·DIG_W) and row ∈ [Y0, Y0+DIG_H).
  - Digit index k is found by per-digit range compare (generate loop), with no divider.
  - d = digit k of bcd_out.
  - Address = (row−Y0)·10·DIG_W + d·DIG_W + (col−X0−k·DIG_W), truncated to ADDR_W.
- Blanking (LZ_BLANK=1): digit k is blanked if it and all more-significant digits are 0. Digit DIGITS−1 is never blanked.
- Inside box and not blanked: pic_num_addr ← address, pic_num_valid ← 1.
- Inside box and blanked: pic_num_addr ← address, pic_num_valid ← 0.
- Outside box: pic_num_addr holds its value, pic_num_valid ← 0.

## Timing
- Reset (asynchronous, any state, including mid-CONV):
  - state=IDLE; pending=0; busy=0; conv_done=0; overflow=0; bcd_out=0; pic_num_addr=0; pic_num_valid=0.
  - An in-flight conversion is discarded.
- Latency: load sampled at edge E0, so CONV covers edges E1..E_BIN_W. At edge E_BIN_W+1, bcd_out, overflow and conv_done update.
- busy is high from E0 through the cycle ending at E_BIN_W+1.
- With pending set, the next conversion starts at E_BIN_W+1 and busy stays high continuously.
- Pixel path: one register stage, so outputs reflect the col/row sampled at the previous edge. bcd_out changing mid-frame takes effect on the next pixel.
- Arithmetic: row/col subtractions 11-bit unsigned, only evaluated inside the box, so no underflow. Product widths are sized to ADDR_W.

## Test plan
- Reset: assert rst mid-CONV → busy=0, bcd_out=0, pic_num_addr=0, pic_num_valid=0 immediately. No conv_done follows after release.
- Defaults, score_bin=255, one-cycle score_load → conv_done exactly 11 cycles later; bcd_out=16'h0255; overflow=0.
- Load 255, then load 999 at cycle 3 and 1000 at cycle 5 → first done shows 0255, busy stays high, second done 11 cycles later shows 1000. Exactly two conv_done pulses.
- DIGITS=3, BIN_W=10, score_bin=1000 → bcd_out=12'h999, overflow=1. A subsequent load of 7 → 12'h007, overflow=0.
- Defaults, bcd 0255:
  - row=290, col=246 → next cycle pic_num_addr=1876, pic_num_valid=1.
  - col=200 → pic_num_valid=0 (blanked zero).
  - col=300 → valid=0, address held at previous value.
- Score 0 with LZ_BLANK=1 → only col ∈ [270,295) gives valid=1, d=0. With LZ_BLANK=0, all four cells are valid.
